// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the memory port arbiter.
// Imported by the arbiter and its testbench.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_DATA  = 2'd1,
    GRANT_INSTR = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the 16-bit memory bus port.
// Data wins ties; a streak counter forces one fetch grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_m_access,
  output logic              data_m_ack,
  input  logic [ADDR_W-1:0] data_m_addr,
  input  logic              data_m_wr_en,
  input  logic [DATA_W-1:0] data_m_data_out,
  input  logic [1:0]        data_m_bytesel,
  output logic [DATA_W-1:0] data_m_data_in,
  input  logic              instr_m_access,
  output logic              instr_m_ack,
  input  logic [ADDR_W-1:0] instr_m_addr,
  output logic [DATA_W-1:0] instr_m_data_in,
  output logic              m_access,
  input  logic              m_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wr_en,
  output logic [DATA_W-1:0] m_data_out,
  output logic [1:0]        m_bytesel,
  input  logic [DATA_W-1:0] m_data_in,
  output logic              grant_data,
  output logic              grant_instr
);

  localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);

  arb_state_e state, state_nxt;
  logic [3:0] streak, streak_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    unique case (state)
      IDLE: begin
        if (data_m_access &&
            (!instr_m_access || streak != MAX_S))
          state_nxt = GRANT_DATA;
        else if (instr_m_access)
          state_nxt = GRANT_INSTR;
        // Streak only counts data wins over a waiting fetch
        if (!instr_m_access)
          streak_nxt = '0;
        else if (state_nxt == GRANT_INSTR)
          streak_nxt = '0;
        else if (state_nxt == GRANT_DATA &&
                 streak != MAX_S)
          streak_nxt = streak + 4'd1;
      end
      GRANT_DATA, GRANT_INSTR: begin
        if (m_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_access    = 1'b0;
    m_addr      = '0;
    m_wr_en     = 1'b0;
    m_data_out  = '0;
    m_bytesel   = 2'b00;
    grant_data  = 1'b0;
    grant_instr = 1'b0;
    unique case (state)
      GRANT_DATA: begin
        m_access   = 1'b1;
        m_addr     = data_m_addr;
        m_wr_en    = data_m_wr_en;
        m_data_out = data_m_data_out;
        m_bytesel  = data_m_bytesel;
        grant_data = 1'b1;
      end
      GRANT_INSTR: begin
        m_access    = 1'b1;
        m_addr      = instr_m_addr;
        m_bytesel   = 2'b11;
        grant_instr = 1'b1;
      end
      default: ;
    endcase
  end

  assign data_m_ack      = m_ack && state == GRANT_DATA;
  assign instr_m_ack     = m_ack && state == GRANT_INSTR;
  assign data_m_data_in  = m_data_in;
  assign instr_m_data_in = m_data_in;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter.
// A transaction-level owner/streak model predicts the bus.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_m_access;
  logic        data_m_ack;
  logic [18:0] data_m_addr;
  logic        data_m_wr_en;
  logic [15:0] data_m_data_out;
  logic [1:0]  data_m_bytesel;
  logic [15:0] data_m_data_in;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [18:0] instr_m_addr;
  logic [15:0] instr_m_data_in;
  logic        m_access;
  logic        m_ack;
  logic [18:0] m_addr;
  logic        m_wr_en;
  logic [15:0] m_data_out;
  logic [1:0]  m_bytesel;
  logic [15:0] m_data_in;
  logic        grant_data;
  logic        grant_instr;

  int n_cmp = 0;
  int n_bad = 0;

  // owner: 0 none, 1 data, 2 instr
  int mdl_owner = 0;
  int mdl_streak = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_m_access  (data_m_access),
    .data_m_ack     (data_m_ack),
    .data_m_addr    (data_m_addr),
    .data_m_wr_en   (data_m_wr_en),
    .data_m_data_out(data_m_data_out),
    .data_m_bytesel (data_m_bytesel),
    .data_m_data_in (data_m_data_in),
    .instr_m_access (instr_m_access),
    .instr_m_ack    (instr_m_ack),
    .instr_m_addr   (instr_m_addr),
    .instr_m_data_in(instr_m_data_in),
    .m_access       (m_access),
    .m_ack          (m_ack),
    .m_addr         (m_addr),
    .m_wr_en        (m_wr_en),
    .m_data_out     (m_data_out),
    .m_bytesel      (m_bytesel),
    .m_data_in      (m_data_in),
    .grant_data     (grant_data),
    .grant_instr    (grant_instr)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic settle();
    logic [18:0] ea;
    logic [15:0] ed;
    logic [1:0]  eb;
    logic        ew;
    #1;
    ea = '0; ed = '0; eb = 2'b00; ew = 1'b0;
    if (mdl_owner == 1) begin
      ea = data_m_addr; ed = data_m_data_out;
      eb = data_m_bytesel; ew = data_m_wr_en;
    end else if (mdl_owner == 2) begin
      ea = instr_m_addr; eb = 2'b11;
    end
    check("m_access", 32'(m_access), 32'(mdl_owner != 0));
    check("m_addr", 32'(m_addr), 32'(ea));
    check("m_wr_en", 32'(m_wr_en), 32'(ew));
    check("m_data_out", 32'(m_data_out), 32'(ed));
    check("m_bytesel", 32'(m_bytesel), 32'(eb));
    check("data_ack", 32'(data_m_ack),
          32'(m_ack && mdl_owner == 1));
    check("instr_ack", 32'(instr_m_ack),
          32'(m_ack && mdl_owner == 2));
    check("grants", {30'd0, grant_instr, grant_data},
          {30'd0, mdl_owner == 2, mdl_owner == 1});
    check("data_in", {data_m_data_in, instr_m_data_in},
          {m_data_in, m_data_in});
  endtask

  // Model advances on the same edge the DUT samples
  task automatic tick();
    int pick;
    @(posedge clk);
    if (reset) begin
      mdl_owner = 0;
      mdl_streak = 0;
    end else if (mdl_owner != 0) begin
      if (m_ack) mdl_owner = 0;
    end else begin
      pick = 0;
      if (data_m_access && instr_m_access)
        pick = (mdl_streak == MAXS) ? 2 : 1;
      else if (data_m_access) pick = 1;
      else if (instr_m_access) pick = 2;
      if (!instr_m_access || pick == 2)
        mdl_streak = 0;
      else if (pick == 1 && mdl_streak < MAXS)
        mdl_streak = mdl_streak + 1;
      mdl_owner = pick;
    end
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0;
    data_m_access = 1'b0;
    data_m_addr = '0;
    data_m_wr_en = 1'b0;
    data_m_data_out = '0;
    data_m_bytesel = 2'b00;
    instr_m_access = 1'b0;
    instr_m_addr = '0;
    m_ack = 1'b0;
    m_data_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    settle(); tick();
    settle(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int g;
    do_reset();
    settle();
    check("rst_acc", 32'(m_access), 32'd0);

    // Idle bus
    for (int i = 0; i < 10; i++) begin
      settle(); tick();
    end

    // Instruction-only read
    instr_m_access = 1'b1;
    instr_m_addr = 19'h00100;
    settle(); tick();
    settle();
    check("ir_acc", 32'(m_access), 32'd1);
    check("ir_addr", 32'(m_addr), 32'h00100);
    m_ack = 1'b1;
    m_data_in = 16'hA55A;
    settle();
    check("ir_iack", 32'(instr_m_ack), 32'd1);
    check("ir_data", 32'(instr_m_data_in), 32'hA55A);
    check("ir_dack", 32'(data_m_ack), 32'd0);
    tick();
    instr_m_access = 1'b0;
    m_ack = 1'b0;
    settle(); tick();

    // Simultaneous requests: data first, then fetch
    data_m_access = 1'b1;
    data_m_wr_en = 1'b1;
    data_m_addr = 19'h7FFFF;
    data_m_data_out = 16'h1234;
    data_m_bytesel = 2'b01;
    instr_m_access = 1'b1;
    instr_m_addr = 19'h00200;
    settle(); tick();
    settle();
    check("sim_gd", 32'(grant_data), 32'd1);
    check("sim_addr", 32'(m_addr), 32'h7FFFF);
    check("sim_dout", 32'(m_data_out), 32'h1234);
    check("sim_bs", 32'(m_bytesel), 32'h1);
    m_ack = 1'b1;
    settle(); tick();
    data_m_access = 1'b0;
    m_ack = 1'b0;
    settle(); tick();
    settle();
    check("sim_gi", 32'(grant_instr), 32'd1);
    check("sim_iaddr", 32'(m_addr), 32'h00200);
    m_ack = 1'b1;
    settle(); tick();
    instr_m_access = 1'b0;
    m_ack = 1'b0;
    settle(); tick();

    // Requester drops mid-transaction
    instr_m_access = 1'b1;
    settle(); tick();
    settle(); tick();
    settle(); tick();
    instr_m_access = 1'b0;
    settle(); tick();
    m_ack = 1'b1;
    settle();
    check("drop_acc", 32'(m_access), 32'd1);
    check("drop_iack", 32'(instr_m_ack), 32'd1);
    tick();
    m_ack = 1'b0;
    settle();
    check("drop_idle", 32'(m_access), 32'd0);
    tick();

    // Reset during a data grant
    data_m_access = 1'b1;
    data_m_wr_en = 1'b0;
    settle(); tick();
    settle();
    check("rmt_gd", 32'(grant_data), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_m_access = 1'b0;
    m_ack = 1'b1;
    settle();
    check("rmt_acc", 32'(m_access), 32'd0);
    check("rmt_dack", 32'(data_m_ack), 32'd0);
    tick();
    m_ack = 1'b0;

    // Starvation bound: 4 data grants then 1 fetch
    do_reset();
    data_m_access = 1'b1;
    instr_m_access = 1'b1;
    g = 0;
    for (int k = 0; k < 50; k++) begin
      m_ack = (mdl_owner != 0);
      settle();
      if (grant_data || grant_instr) begin
        check("starve", 32'(grant_instr),
              32'(g % (MAXS + 1) == MAXS));
        g++;
      end
      tick();
    end
    check("starve_n", 32'(g), 32'd25);
    do_reset();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      data_m_access = ($urandom_range(0, 2) != 0);
      instr_m_access = ($urandom_range(0, 2) != 0);
      data_m_addr = 19'($urandom);
      data_m_wr_en = 1'($urandom);
      data_m_data_out = 16'($urandom);
      data_m_bytesel = 2'($urandom);
      instr_m_addr = 19'($urandom);
      m_ack = ($urandom_range(0, 2) == 0);
      m_data_in = 16'($urandom);
      settle(); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
